mem_csr_ctrl: RTL and testbench

Host-facing CSR and command sequencer directly upstream of the local-memory FSM in the hello-mem AFU. It decodes 64-bit MMIO reads and writes into address, data, burst and mode registers. It issues single-cycle read/write command pulses to the memory FSM, handshaking on `ready_for_sw_cmd`. It tracks completion through `rdwr_done` and exposes the FSM's done/status bits back to software.

---
 rtl/mem_csr_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_csr_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_csr_ctrl.sv
// mem_csr_ctrl: host-facing CSR block and command sequencer in front of the
// local-memory FSM. MMIO writes load address/burst/data/mode registers and
// launch single read or write commands. MMIO reads expose those registers
// together with the FSM's done/status bits.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   mmio_wr_valid/addr/data             64-bit MMIO write, 8-byte aligned offset
//   mmio_rd_valid/addr/tid              MMIO read request
//   mmio_rd_rsp_valid/data/tid          read response, one cycle after request
//   avm_address/writedata/burstcount    registered command fields
//   avm_write, avm_read                 one-cycle command pulses
//   mem_testmode                        address-test enable
//   rdwr_reset                          one-cycle done/status clear pulse
//   avm_readdata, rdwr_done, rdwr_status,
//   addr_test_status, addr_test_done,
//   ready_for_sw_cmd                    from the memory FSM
//
// Build option: define MEM_CSR_TIMEOUT_EN to add a watchdog that aborts a
// command after TIMEOUT_CYC cycles spent in one wait state.
module mem_csr_ctrl #(
  parameter int          ADDR_W      = 27,
  parameter int          BURST_W     = 7,
  parameter int          TIMEOUT_CYC = 65535,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mmio_wr_valid,
  input  logic [15:0]        mmio_wr_addr,
  input  logic [63:0]        mmio_wr_data,
  input  logic               mmio_rd_valid,
  input  logic [15:0]        mmio_rd_addr,
  input  logic [8:0]         mmio_rd_tid,
  output logic               mmio_rd_rsp_valid,
  output logic [63:0]        mmio_rd_rsp_data,
  output logic [8:0]         mmio_rd_rsp_tid,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [63:0]        avm_writedata,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic               avm_write,
  output logic               avm_read,
  output logic               mem_testmode,
  output logic               rdwr_reset,
  input  logic [63:0]        avm_readdata,
  input  logic [1:0]         rdwr_done,
  input  logic [4:0]         rdwr_status,
  input  logic [4:0]         addr_test_status,
  input  logic               addr_test_done,
  input  logic               ready_for_sw_cmd
);
  localparam logic [63:0] DFH = 64'h1000_0000_0000_1000;

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_RDY, ISSUE, WAIT_DONE} state_t;

  state_t      state;
  logic        is_wr;
  logic        overrun, timeout;
  logic [15:0] done_cnt;
  logic        busy, guarded_wr, rdwr_wr, rdwr_blocked, set_overrun, cmd_go, cmd_done;
  logic [63:0] rd_data;

`ifdef MEM_CSR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  assign busy = (state != IDLE);

  always_comb begin
    guarded_wr   = mmio_wr_valid && (mmio_wr_addr == 16'h0040 || mmio_wr_addr == 16'h0048 ||
                                     mmio_wr_addr == 16'h0050 || mmio_wr_addr == 16'h0058 ||
                                     mmio_wr_addr == 16'h0068);
    rdwr_wr      = mmio_wr_valid && (mmio_wr_addr == 16'h0050);
    rdwr_blocked = mem_testmode && !addr_test_done;
    set_overrun  = (guarded_wr && busy) || (rdwr_wr && rdwr_blocked);
    cmd_go       = rdwr_wr && !busy && !rdwr_blocked && (mmio_wr_data[1:0] != 2'b00);
    cmd_done     = is_wr ? rdwr_done[0] : rdwr_done[1];
  end

  // Read mux sees register values before any same-cycle write lands.
  always_comb begin
    rd_data = '0;
    case (mmio_rd_addr)
      16'h0000: rd_data = DFH;
      16'h0008: rd_data = AFU_ID_L;
      16'h0010: rd_data = AFU_ID_H;
      16'h0040: rd_data[ADDR_W-1:0]  = avm_address;
      16'h0048: rd_data[BURST_W-1:0] = avm_burstcount;
      16'h0058: rd_data = avm_writedata;
      16'h0060: rd_data = avm_readdata;
      16'h0068: rd_data[0] = mem_testmode;
      16'h0070: rd_data[5:0] = {addr_test_done, addr_test_status};
      16'h0078: begin
        rd_data[1:0]   = rdwr_done;
        rd_data[6:2]   = rdwr_status;
        rd_data[8]     = busy;
        rd_data[9]     = overrun;
        rd_data[10]    = timeout;
        rd_data[31:16] = done_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      is_wr             <= 1'b0;
      avm_address       <= '0;
      avm_writedata     <= '0;
      avm_burstcount    <= BURST_W'(1);
      mem_testmode      <= 1'b0;
      avm_write         <= 1'b0;
      avm_read          <= 1'b0;
      rdwr_reset        <= 1'b0;
      overrun           <= 1'b0;
      timeout           <= 1'b0;
      done_cnt          <= '0;
      mmio_rd_rsp_valid <= 1'b0;
      mmio_rd_rsp_data  <= '0;
      mmio_rd_rsp_tid   <= '0;
`ifdef MEM_CSR_TIMEOUT_EN
      tmo_cnt           <= '0;
`endif
    end else begin
      mmio_rd_rsp_valid <= mmio_rd_valid;
      mmio_rd_rsp_tid   <= mmio_rd_tid;
      mmio_rd_rsp_data  <= rd_data;

      // Command-field registers double as the avm_* outputs; locking them
      // while busy keeps the command stable until the return to IDLE.
      if (mmio_wr_valid && !busy) begin
        case (mmio_wr_addr)
          16'h0040: avm_address    <= mmio_wr_data[ADDR_W-1:0];
          16'h0048: avm_burstcount <= (mmio_wr_data[BURST_W-1:0] == '0) ? BURST_W'(1)
                                                                        : mmio_wr_data[BURST_W-1:0];
          16'h0058: avm_writedata  <= mmio_wr_data;
          16'h0068: mem_testmode   <= mmio_wr_data[0];
          default: ;
        endcase
      end

      if (mmio_wr_valid && mmio_wr_addr == 16'h0078) begin
        if (mmio_wr_data[9])  overrun <= 1'b0;
        if (mmio_wr_data[10]) timeout <= 1'b0;
      end
      if (set_overrun) overrun <= 1'b1;

      avm_write  <= 1'b0;
      avm_read   <= 1'b0;
      rdwr_reset <= 1'b0;

      case (state)
        IDLE: if (cmd_go) begin
          is_wr      <= mmio_wr_data[0];   // bit0 wins when both are set
          rdwr_reset <= 1'b1;
          state      <= CLEAR;
        end
        CLEAR: begin
          state <= WAIT_RDY;
`ifdef MEM_CSR_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT_RDY: begin
          if (ready_for_sw_cmd) begin
            avm_write <= is_wr;
            avm_read  <= !is_wr;
            state     <= ISSUE;
          end
`ifdef MEM_CSR_TIMEOUT_EN
          else if (tmo_hit) begin
            timeout    <= 1'b1;
            rdwr_reset <= 1'b1;
            state      <= IDLE;
          end else tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        ISSUE: begin
          state <= WAIT_DONE;
`ifdef MEM_CSR_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT_DONE: begin
          if (cmd_done) begin
            done_cnt <= done_cnt + 1'b1;
            state    <= IDLE;
          end
`ifdef MEM_CSR_TIMEOUT_EN
          else if (tmo_hit) begin
            timeout    <= 1'b1;
            rdwr_reset <= 1'b1;
            state      <= IDLE;
          end else tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_csr_ctrl.sv
module tb_mem_csr_ctrl;
  localparam int          ADDR_W  = 27;
  localparam int          BURST_W = 7;
  localparam logic [63:0] ID_L    = 64'h1122_3344_5566_7788;
  localparam logic [63:0] ID_H    = 64'h99AA_BBCC_DDEE_FF00;

  logic clk = 1'b0;
  logic reset;
  logic mmio_wr_valid, mmio_rd_valid;
  logic [15:0] mmio_wr_addr, mmio_rd_addr;
  logic [63:0] mmio_wr_data;
  logic [8:0]  mmio_rd_tid;
  logic        mmio_rd_rsp_valid;
  logic [63:0] mmio_rd_rsp_data;
  logic [8:0]  mmio_rd_rsp_tid;
  logic [ADDR_W-1:0]  avm_address;
  logic [63:0]        avm_writedata;
  logic [BURST_W-1:0] avm_burstcount;
  logic avm_write, avm_read, mem_testmode, rdwr_reset;
  logic [63:0] avm_readdata;
  logic [1:0]  rdwr_done;
  logic [4:0]  rdwr_status, addr_test_status;
  logic        addr_test_done, ready_for_sw_cmd;

  mem_csr_ctrl #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .TIMEOUT_CYC(16),
                 .AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (
    .clk(clk), .reset(reset),
    .mmio_wr_valid(mmio_wr_valid), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_valid(mmio_rd_valid), .mmio_rd_addr(mmio_rd_addr), .mmio_rd_tid(mmio_rd_tid),
    .mmio_rd_rsp_valid(mmio_rd_rsp_valid), .mmio_rd_rsp_data(mmio_rd_rsp_data),
    .mmio_rd_rsp_tid(mmio_rd_rsp_tid),
    .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_burstcount(avm_burstcount),
    .avm_write(avm_write), .avm_read(avm_read), .mem_testmode(mem_testmode),
    .rdwr_reset(rdwr_reset), .avm_readdata(avm_readdata), .rdwr_done(rdwr_done),
    .rdwr_status(rdwr_status), .addr_test_status(addr_test_status),
    .addr_test_done(addr_test_done), .ready_for_sw_cmd(ready_for_sw_cmd)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: software-visible register contents and a memory image.
  logic [ADDR_W-1:0]  m_addr;
  logic [BURST_W-1:0] m_burst;
  logic [63:0]        m_wdata;
  logic               m_ovr, m_tmo, m_busy;
  logic [15:0]        m_cnt;
  logic [63:0]        mem [int unsigned];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_valid = 1'b1; mmio_wr_addr = a; mmio_wr_data = d;
    step();
    mmio_wr_valid = 1'b0;
  endtask

  task automatic mmio_rd(input logic [15:0] a, output logic [63:0] d);
    logic [8:0] tid;
    tid = 9'($urandom);
    mmio_rd_valid = 1'b1; mmio_rd_addr = a; mmio_rd_tid = tid;
    step();
    mmio_rd_valid = 1'b0;
    chk("rsp_valid", 64'(mmio_rd_rsp_valid), 64'd1);
    chk("rsp_tid", 64'(mmio_rd_rsp_tid), 64'(tid));
    d = mmio_rd_rsp_data;
  endtask

  function automatic logic [63:0] exp_status();
    logic [63:0] s;
    s = '0;
    s[1:0]   = rdwr_done;
    s[6:2]   = rdwr_status;
    s[8]     = m_busy;
    s[9]     = m_ovr;
`ifdef MEM_CSR_TIMEOUT_EN
    s[10]    = m_tmo;
`endif
    s[31:16] = m_cnt;
    return s;
  endfunction

  function automatic logic [63:0] mem_at(input logic [ADDR_W-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 64'h0;
  endfunction

  // One command from MEM_RDWR write to completion, ready held low for d
  // cycles of WAIT_RDY and done raised lat cycles after the pulse.
  task automatic run_cmd(input bit is_wr, input int d, input int lat, input bit do_ovr);
    logic [63:0] r;
    ready_for_sw_cmd = 1'b0;
    mmio_wr(16'h0050, is_wr ? (($urandom_range(0, 1) == 1) ? 64'h3 : 64'h1) : 64'h2);
    m_busy = 1'b1;
    chk("clear_pulse", 64'(rdwr_reset), 64'd1);
    rdwr_done = 2'b00;                       // memory FSM clears on rdwr_reset
    step();
    chk("clear_single", 64'(rdwr_reset), 64'd0);
    chk("no_early_pulse", 64'({avm_write, avm_read}), 64'd0);
    for (int k = 0; k < d; k++) begin
      step();
      chk("no_pulse_not_ready", 64'({avm_write, avm_read}), 64'd0);
    end
    ready_for_sw_cmd = 1'b1;
    step();
    ready_for_sw_cmd = 1'b0;
    chk("cmd_pulse", 64'({avm_write, avm_read}), is_wr ? 64'd2 : 64'd1);
    chk("cmd_addr", 64'(avm_address), 64'(m_addr));
    chk("cmd_wdata", avm_writedata, m_wdata);
    chk("cmd_burst", 64'(avm_burstcount), 64'(m_burst));
    step();
    chk("pulse_single", 64'({avm_write, avm_read}), 64'd0);
    if (do_ovr) begin
      mmio_wr(16'h0040, 64'(~m_addr));
      mmio_wr(16'h0050, 64'h1);
      m_ovr = 1'b1;
    end
    mmio_rd(16'h0078, r);
    chk("status_busy", r, exp_status());
    for (int k = 0; k < lat; k++) step();
    if (!is_wr) avm_readdata = mem_at(m_addr);
    rdwr_done = is_wr ? 2'b01 : 2'b10;
    step();
    m_busy = 1'b0;
    m_cnt++;
    mmio_rd(16'h0078, r);
    chk("status_done", r, exp_status());
    if (is_wr) mem[int'(m_addr)] = m_wdata;
    else begin
      mmio_rd(16'h0060, r);
      chk("rddata", r, mem_at(m_addr));
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] old;
    bit is_wr, found;
    int n;

    reset = 1'b1;
    mmio_wr_valid = 0; mmio_wr_addr = 0; mmio_wr_data = 0;
    mmio_rd_valid = 0; mmio_rd_addr = 0; mmio_rd_tid = 0;
    avm_readdata = 0; rdwr_done = 0; rdwr_status = 0;
    addr_test_status = 0; addr_test_done = 0; ready_for_sw_cmd = 0;
    m_addr = 0; m_burst = 1; m_wdata = 0; m_ovr = 0; m_tmo = 0; m_busy = 0; m_cnt = 0;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_burst", 64'(avm_burstcount), 64'd1);
    chk("rst_addr", 64'(avm_address), 64'd0);
    chk("rst_pulses", 64'({avm_write, avm_read, rdwr_reset, mem_testmode}), 64'd0);
    chk("rst_rsp_valid", 64'(mmio_rd_rsp_valid), 64'd0);

    mmio_rd(16'h0000, r); chk("dfh", r, 64'h1000_0000_0000_1000);
    mmio_rd(16'h0008, r); chk("afu_id_l", r, ID_L);
    mmio_rd(16'h0010, r); chk("afu_id_h", r, ID_H);
    mmio_rd(16'h0048, r); chk("rst_burst_rd", r, 64'd1);
    mmio_rd(16'h0078, r); chk("rst_status", r, exp_status());
    mmio_rd(16'h0030, r); chk("unmapped_rd", r, 64'd0);

    addr_test_status = 5'($urandom); addr_test_done = 1'b1;
    mmio_rd(16'h0070, r); chk("test_status", r, 64'({addr_test_done, addr_test_status}));

    mmio_wr(16'h0048, 64'h0);
    mmio_rd(16'h0048, r); chk("burst_zero", r, 64'd1);
    mmio_wr(16'h0060, 64'hFFFF);             // RO, dropped
    mmio_wr(16'h0038, 64'hFFFF);             // unmapped, dropped
    mmio_rd(16'h0078, r); chk("ro_write_dropped", r, exp_status());

    // Same-cycle read and write of MEM_WRDATA returns the old value.
    old = m_wdata;
    m_wdata = {$urandom, $urandom};
    mmio_wr_valid = 1'b1; mmio_wr_addr = 16'h0058; mmio_wr_data = m_wdata;
    mmio_rd_valid = 1'b1; mmio_rd_addr = 16'h0058; mmio_rd_tid = 9'h1A5;
    step();
    mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
    chk("rw_same_cycle", mmio_rd_rsp_data, old);
    mmio_rd(16'h0058, r); chk("rw_new_value", r, m_wdata);

    for (int i = 0; i < 8; i++) begin
      is_wr = (i == 0) || (i != 1 && $urandom_range(0, 1) == 1);
      if (is_wr) m_addr = ADDR_W'($urandom);
      m_wdata = {$urandom, $urandom};
      m_burst = BURST_W'($urandom_range(1, 127));
      rdwr_status = 5'($urandom);
      mmio_wr(16'h0040, 64'(m_addr));
      mmio_wr(16'h0048, 64'(m_burst));
      mmio_wr(16'h0058, m_wdata);
      mmio_rd(16'h0040, r); chk("addr_rb", r, 64'(m_addr));
      mmio_rd(16'h0048, r); chk("burst_rb", r, 64'(m_burst));
      mmio_rd(16'h0058, r); chk("wdata_rb", r, m_wdata);
      run_cmd(is_wr, (i == 1) ? 10 : $urandom_range(0, 4), $urandom_range(0, 3),
              (i == 2) || (i == 5));
      if (m_ovr) begin
        mmio_rd(16'h0040, r); chk("addr_kept_busy", r, 64'(m_addr));
        mmio_wr(16'h0078, 64'h0);
        mmio_rd(16'h0078, r); chk("w0_keeps_ovr", r, exp_status());
        mmio_wr(16'h0078, 64'h200);
        m_ovr = 1'b0;
        mmio_rd(16'h0078, r); chk("w1c_ovr", r, exp_status());
      end
    end

    // MEM_RDWR blocked while address test is enabled but not finished.
    mmio_wr(16'h0068, 64'h1);
    chk("testmode_out", 64'(mem_testmode), 64'd1);
    addr_test_done = 1'b0;
    mmio_wr(16'h0050, 64'h1);
    chk("blocked_no_clear", 64'(rdwr_reset), 64'd0);
    m_ovr = 1'b1;
    mmio_rd(16'h0078, r); chk("blocked_status", r, exp_status());
    addr_test_done = 1'b1;
    mmio_wr(16'h0068, 64'h0);
    mmio_wr(16'h0078, 64'h200);
    m_ovr = 1'b0;
    mmio_rd(16'h0068, r); chk("testmode_rb", r, 64'd0);

`ifdef MEM_CSR_TIMEOUT_EN
    ready_for_sw_cmd = 1'b0;
    mmio_wr(16'h0050, 64'h1);
    chk("tmo_clear_pulse", 64'(rdwr_reset), 64'd1);
    rdwr_done = 2'b00;
    found = 1'b0; n = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      step();
      if (rdwr_reset) begin found = 1'b1; n = k; end
    end
    chk("tmo_latency", 64'(n), 64'd17);
    m_tmo = 1'b1;
    mmio_rd(16'h0078, r); chk("tmo_status", r, exp_status());
    mmio_wr(16'h0078, 64'h400);
    m_tmo = 1'b0;
    mmio_rd(16'h0078, r); chk("tmo_w1c", r, exp_status());
`endif

    // Reset mid-command: no pulse, registers and sticky state cleared.
    found = 1'b0;
    ready_for_sw_cmd = 1'b0;
    mmio_wr(16'h0050, 64'h2);
    mmio_wr(16'h0040, 64'h55);               // busy: dropped, sets overrun
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_addr = 0; m_burst = 1; m_wdata = 0; m_ovr = 0; m_tmo = 0; m_busy = 0; m_cnt = 0;
    chk("midrst_outs", 64'({avm_write, avm_read, rdwr_reset, mem_testmode}), 64'd0);
    chk("midrst_burst", 64'(avm_burstcount), 64'd1);
    ready_for_sw_cmd = 1'b1;
    step();
    chk("midrst_no_pulse", 64'({avm_write, avm_read}), 64'd0);
    step();
    chk("midrst_no_pulse2", 64'({avm_write, avm_read}), 64'd0);
    mmio_rd(16'h0078, r); chk("midrst_status", r, exp_status());
    mmio_rd(16'h0040, r); chk("midrst_addr", r, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
